// File: rtl/avalon_pio_ext_pkg.sv
// Shared definitions for the avalon_pio_ext GPIO block: register word offsets,
// capture-edge selection and the INFO word layout.
// Package only: no latency or backpressure of its own.
package pio_pkg;

    localparam int PIO_ADDR_W = 3;

    localparam logic [PIO_ADDR_W-1:0] PIO_REG_DATA     = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_DIR      = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_IRQ_MASK = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_EDGE_CAP = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_OUTSET   = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_OUTCLR   = 3'd5;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_OUTTGL   = 3'd6;
    localparam logic [PIO_ADDR_W-1:0] PIO_REG_INFO     = 3'd7;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // INFO = {8'd0, edge[1:0], 6'd0, sync[3:0], 6'd0, width[5:0]}
    function automatic logic [31:0] pio_info_word(input int width, input int sync_stages,
                                                  input int edge_type);
        logic [31:0] w;
        w        = '0;
        w[5:0]   = width[5:0];
        w[15:12] = sync_stages[3:0];
        w[23:22] = edge_type[1:0];
        return w;
    endfunction

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for avalon_pio_ext (address, strobes, data, readdatavalid).
// Latency: wires only; the slave answers reads one cycle after avs_read.
// Backpressure: none, there is no waitrequest; every strobe is accepted in its cycle.
interface avalon_pio_ext_if;
    import pio_pkg::*;

    logic [PIO_ADDR_W-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [31:0]           avs_writedata;
    logic [31:0]           avs_readdata;
    logic                  avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );

endinterface

// File: rtl/pio_bit_debounce.sv
// Single-bit debouncer: output follows the input only after CYCLES consecutive differing cycles.
// Latency: CYCLES cycles from a stable change at i_din to o_dout.
// Backpressure: none (free-running per clock).
// Ports: clk, reset (sync, active-high), i_din (synchronised bit), o_dout (debounced bit).
module pio_bit_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_dout
);

    localparam int                CNT_W  = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // The counter only runs while input and stable value disagree; any agreement
    // reloads it, so a glitch shorter than CYCLES never reaches the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= RELOAD;
            r_stable <= 1'b0;
        end else if (i_din == r_stable) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == CNT_W'(1)) begin
            r_stable <= i_din;
            r_cnt    <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_dout = r_stable;

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM GPIO: per-bit direction, atomic set/clr/toggle, synchronised inputs, edge capture, masked irq.
// Latency: writes act on the strobe edge; reads return data 1 cycle later; inputs visible after SYNC_STAGES.
// Backpressure: none, no waitrequest; every read and write is accepted in the cycle it is strobed.
// Ports: clk, reset (sync, active-high), avs (Avalon slave modport), pio_in (async pads),
//        pio_out (output register), pio_oe (= direction register), irq (registered level).
// Optional: define PIO_DEBOUNCE_EN to insert a pio_bit_debounce per input bit after the synchroniser.
module avalon_pio_ext
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] DIR_RESET       = '0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    avalon_pio_ext_if.slave  avs,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    localparam edge_type_e  EDGE_SEL  = edge_type_e'(EDGE_TYPE[1:0]);
    localparam logic [31:0] INFO_WORD = pio_info_word(WIDTH, SYNC_STAGES, EDGE_TYPE);

    // Capture stays off until the input pipeline has been refilled after reset,
    // so a pin already high at release is not mistaken for an edge. With the
    // debouncer present its settling time is part of that pipeline.
`ifdef PIO_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_cap;
    logic                              r_irq;
    logic [31:0]                       r_rdata;
    logic                              r_rdv;
    logic [ARM_W-1:0]                  r_arm_cnt;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_new_edge;
    logic [WIDTH-1:0] w_cap_clr;
    logic             w_armed;
    logic [31:0]      w_rd_data;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_wdata = avs.avs_writedata[WIDTH-1:0];
    assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

`ifdef PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        pio_bit_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .i_din  (w_sync[g]),
            .o_dout (w_in[g])
        );
    end
`else
    assign w_in = w_sync;
`endif

    always_comb begin
        w_edge_raw = '0;
        case (EDGE_SEL)
            EDGE_RISE: w_edge_raw = w_in & ~r_prev;
            EDGE_FALL: w_edge_raw = ~w_in & r_prev;
            default:   w_edge_raw = w_in ^ r_prev;
        endcase
    end

    // Output-direction bits never capture; existing capture bits are left alone.
    assign w_new_edge = w_edge_raw & ~r_dir & {WIDTH{w_armed}};
    assign w_cap_clr  = (avs.avs_write && avs.avs_address == PIO_REG_EDGE_CAP) ? w_wdata : '0;

    always_comb begin
        w_rd_data = '0;
        case (avs.avs_address)
            PIO_REG_DATA:     w_rd_data[WIDTH-1:0] = (r_out & r_dir) | (w_in & ~r_dir);
            PIO_REG_DIR:      w_rd_data[WIDTH-1:0] = r_dir;
            PIO_REG_IRQ_MASK: w_rd_data[WIDTH-1:0] = r_mask;
            PIO_REG_EDGE_CAP: w_rd_data[WIDTH-1:0] = r_cap;
            PIO_REG_INFO:     w_rd_data            = INFO_WORD;
            default:          w_rd_data            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_prev    <= '0;
            r_out     <= OUT_RESET;
            r_dir     <= DIR_RESET;
            r_mask    <= '0;
            r_cap     <= '0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
            r_rdv     <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pio_in};
            r_prev <= w_in;

            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end

            // Read data is sampled from pre-write state, so a read colliding
            // with a write returns the old value.
            r_rdv <= avs.avs_read;
            if (avs.avs_read) begin
                r_rdata <= w_rd_data;
            end

            if (avs.avs_write) begin
                case (avs.avs_address)
                    PIO_REG_DATA:     r_out  <= w_wdata;
                    PIO_REG_DIR:      r_dir  <= w_wdata;
                    PIO_REG_IRQ_MASK: r_mask <= w_wdata;
                    PIO_REG_OUTSET:   r_out  <= r_out | w_wdata;
                    PIO_REG_OUTCLR:   r_out  <= r_out & ~w_wdata;
                    PIO_REG_OUTTGL:   r_out  <= r_out ^ w_wdata;
                    default: ;
                endcase
            end

            // A new edge in the same cycle as its W1C wins.
            r_cap <= (r_cap & ~w_cap_clr) | w_new_edge;
            r_irq <= |(r_cap & r_mask);
        end
    end

    // Gating with reset drops the valid of a read that was in flight when reset arrived.
    assign avs.avs_readdatavalid = r_rdv & ~reset;
    assign avs.avs_readdata      = r_rdata;
    assign pio_out               = r_out;
    assign pio_oe                = r_dir;
    assign irq                   = r_irq;

endmodule

// File: tb/tb_avalon_pio_ext.sv
module tb_avalon_pio_ext;
    import pio_pkg::*;

    localparam int S = 2;
`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] pio_in;
    logic [7:0] pio_out;
    logic [7:0] pio_oe;
    logic       irq;

    avalon_pio_ext_if u_bus();

    avalon_pio_ext #(
        .WIDTH           (8),
        .SYNC_STAGES     (S),
        .EDGE_TYPE       (0),
        .DIR_RESET       (8'h0F),
        .OUT_RESET       (8'h05),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .avs     (u_bus),
        .pio_in  (pio_in),
        .pio_out (pio_out),
        .pio_oe  (pio_oe),
        .irq     (irq)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        u_bus.avs_address   = addr;
        u_bus.avs_writedata = data;
        u_bus.avs_write     = 1'b1;
        tick(1);
        u_bus.avs_write     = 1'b0;
    endtask

    // Issues one read and waits (bounded) for readdatavalid.
    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        int n;
        u_bus.avs_address = addr;
        u_bus.avs_read    = 1'b1;
        tick(1);
        u_bus.avs_read    = 1'b0;
        n = 0;
        while (u_bus.avs_readdatavalid !== 1'b1 && n < 4) begin
            tick(1);
            n++;
        end
        checks++;
        if (u_bus.avs_readdatavalid !== 1'b1 || n != 0) begin
            errors++;
            $display("FAIL read_latency addr %0d: valid after %0d extra cycles, required 0", addr, n);
        end
        data = u_bus.avs_readdata;
    endtask

    task automatic test_reset;
        logic [2:0]  addrs [7];
        logic [31:0] exps  [7];
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if (pio_oe !== 8'h0F) begin errors++; $display("FAIL reset_oe: got %h required 0f", pio_oe); end
        checks++;
        if (pio_out !== 8'h05) begin errors++; $display("FAIL reset_out: got %h required 05", pio_out); end
        checks++;
        if (irq !== 1'b0 || u_bus.avs_readdatavalid !== 1'b0 || u_bus.avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq %b rdv %b rdata %h required 0 0 0",
                     irq, u_bus.avs_readdatavalid, u_bus.avs_readdata);
        end
        // INFO: WIDTH=8 in [5:0], SYNC_STAGES=2 in [15:12], EDGE_TYPE=0 in [23:22].
        addrs = '{PIO_REG_INFO, PIO_REG_DATA, PIO_REG_DIR, PIO_REG_IRQ_MASK,
                  PIO_REG_EDGE_CAP, PIO_REG_OUTSET, PIO_REG_OUTTGL};
        exps  = '{32'h0000_2008, 32'h05, 32'h0F, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) exp_q.push_back(exps[i]);
        for (int i = 0; i < 7; i++) begin
            bus_read(addrs[i], rd);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL reset_read addr %0d: got %h required %h", addrs[i], rd, e); end
        end
    endtask

    task automatic test_set_clr_tgl;
        logic [2:0] addrs [3];
        logic [7:0] data  [3];
        bus_write(PIO_REG_DATA, 32'h05);
        addrs = '{PIO_REG_OUTSET, PIO_REG_OUTCLR, PIO_REG_OUTTGL};
        data  = '{8'hF0, 8'h30, 8'h01};
        exp_q.push_back(32'hF5);
        exp_q.push_back(32'hC5);
        exp_q.push_back(32'hC4);
        for (int i = 0; i < 3; i++) begin
            bus_write(addrs[i], {24'hFFFFFF, data[i]});
            e = exp_q.pop_front();
            checks++;
            if (pio_out !== e[7:0]) begin errors++; $display("FAIL atomic_op %0d: pio_out %h required %h", i, pio_out, e[7:0]); end
        end
    endtask

    task automatic test_edge_irq;
        bus_write(PIO_REG_DIR, 32'h0);
        checks++;
        if (pio_oe !== 8'h00 || pio_out !== 8'hC4) begin
            errors++;
            $display("FAIL dir_change: oe %h out %h required 00 c4", pio_oe, pio_out);
        end
        bus_write(PIO_REG_IRQ_MASK, 32'h01);
        pio_in = 8'h01;
        tick(S + 1 + DB);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", irq); end
        exp_q.push_back(32'h01);
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL edge_cap_set: got %h required %h", rd, e); end
        bus_write(PIO_REG_EDGE_CAP, 32'h01);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
        exp_q.push_back(32'h0);
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL edge_cap_w1c: got %h required %h", rd, e); end
    endtask

    task automatic test_w1c_collision;
        bus_write(PIO_REG_IRQ_MASK, 32'h04);
        pio_in = 8'h05;
        tick(S + 4 + DB);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL bit2_irq: got %b required 1", irq); end
        pio_in = 8'h01;
        tick(S + 4 + DB);
        pio_in = 8'h05;
        tick(S + DB);
        // This write lands on the same edge as the new capture of bit 2.
        bus_write(PIO_REG_EDGE_CAP, 32'h04);
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b required 1", irq); end
        exp_q.push_back(32'h04);
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL collision_cap: got %h required %h", rd, e); end
        bus_write(PIO_REG_EDGE_CAP, 32'hFF);
        bus_write(PIO_REG_IRQ_MASK, 32'h0);
    endtask

    task automatic test_rw_collision;
        exp_q.push_back(32'h0);
        u_bus.avs_address   = PIO_REG_DIR;
        u_bus.avs_writedata = 32'h3C;
        u_bus.avs_read      = 1'b1;
        u_bus.avs_write     = 1'b1;
        tick(1);
        u_bus.avs_read      = 1'b0;
        u_bus.avs_write     = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (u_bus.avs_readdatavalid !== 1'b1 || u_bus.avs_readdata !== e) begin
            errors++;
            $display("FAIL rw_collision: rdv %b data %h required 1 %h", u_bus.avs_readdatavalid, u_bus.avs_readdata, e);
        end
        checks++;
        if (pio_oe !== 8'h3C) begin errors++; $display("FAIL rw_collision_dir: oe %h required 3c", pio_oe); end
        bus_write(PIO_REG_DIR, 32'h0);
    endtask

    task automatic test_data_mux;
        bus_write(PIO_REG_DIR, 32'h0F);
        pio_in = 8'hA5;
        tick(S + 2 + DB);
        // Out C4 on bits 3:0, pins A5 on bits 7:4.
        exp_q.push_back(32'hA4);
        bus_read(PIO_REG_DATA, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL data_mux: got %h required %h", rd, e); end
        bus_write(PIO_REG_DATA, 32'hFFFF_FF5A);
        checks++;
        if (pio_out !== 8'h5A) begin errors++; $display("FAIL data_wide_write: out %h required 5a", pio_out); end
        bus_write(PIO_REG_DIR, 32'hFFFF_FFFF);
        bus_write(PIO_REG_INFO, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFF);
        exp_q.push_back(32'h5A);
        exp_q.push_back(32'h0000_2008);
        bus_read(PIO_REG_DIR, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL dir_upper_bits: got %h required %h", rd, e); end
        bus_read(PIO_REG_DATA, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL data_all_out: got %h required %h", rd, e); end
        bus_read(PIO_REG_INFO, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL info_readonly: got %h required %h", rd, e); end
        pio_in = 8'h00;
        bus_write(PIO_REG_DIR, 32'h0);
        tick(S + 4 + DB);
        bus_write(PIO_REG_EDGE_CAP, 32'hFF);
    endtask

    task automatic test_reset_edge;
        int bad_rdv;
        pio_in = 8'hF0;
        tick(2);
        u_bus.avs_address = PIO_REG_INFO;
        u_bus.avs_read    = 1'b1;
        tick(1);
        u_bus.avs_read    = 1'b0;
        reset             = 1'b1;
        bad_rdv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (u_bus.avs_readdatavalid !== 1'b0) bad_rdv++;
            tick(1);
        end
        reset = 1'b0;
        for (int i = 0; i < S + 8 + DB; i++) begin
            @(negedge clk);
            if (u_bus.avs_readdatavalid !== 1'b0) bad_rdv++;
        end
        tick(1);
        checks++;
        if (bad_rdv != 0) begin errors++; $display("FAIL reset_mid_read: %0d valid cycles, required 0", bad_rdv); end
        exp_q.push_back(32'h0);
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL reset_no_spurious: got %h required %h", rd, e); end
        pio_in = 8'hE0;
        tick(S + 4 + DB);
        pio_in = 8'hF0;
        tick(S + 4 + DB);
        exp_q.push_back(32'h10);
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL rearmed_capture: got %h required %h", rd, e); end
    endtask

    task automatic test_glitch;
        logic [31:0] exp_cap;
        bus_write(PIO_REG_DIR, 32'h0);
        pio_in = 8'h00;
        tick(S + 6 + DB);
        bus_write(PIO_REG_EDGE_CAP, 32'hFF);
        pio_in = 8'h02;
        tick(3);
        pio_in = 8'h00;
        tick(15);
`ifdef PIO_DEBOUNCE_EN
        exp_cap = 32'h0;
`else
        exp_cap = 32'h02;
`endif
        exp_q.push_back(32'h0);
        exp_q.push_back(exp_cap);
        bus_read(PIO_REG_DATA, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL glitch_data: got %h required %h", rd, e); end
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL glitch_cap: got %h required %h", rd, e); end
        bus_write(PIO_REG_EDGE_CAP, 32'hFF);
        pio_in = 8'h02;
        tick(S + 8 + DB);
        exp_q.push_back(32'h02);
        exp_q.push_back(32'h02);
        bus_read(PIO_REG_DATA, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL stable_data: got %h required %h", rd, e); end
        bus_read(PIO_REG_EDGE_CAP, rd);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL stable_cap: got %h required %h", rd, e); end
    endtask

    initial begin
        reset               = 1'b1;
        pio_in              = 8'h00;
        u_bus.avs_address   = '0;
        u_bus.avs_read      = 1'b0;
        u_bus.avs_write     = 1'b0;
        u_bus.avs_writedata = '0;
        tick(2);
        test_reset();
        test_set_clr_tgl();
        test_edge_irq();
        test_w1c_collision();
        test_rw_collision();
        test_data_mux();
        test_reset_edge();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
